// File: rtl/mem_access_unit.sv
// mem_access_unit: RISC-V data-memory access stage with alignment checks, lane steering, bus timeout and load extension
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);
  state_t state;
  logic [7:0] cnt;
  logic store_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [4:0] rd_q;
  logic legal, mis;
  logic [3:0] be;
  logic [31:0] wd, s, ext;
  assign req_ready = state == IDLE;
  // decode the incoming request and extend the returning load data
  always_comb begin
    legal = req_store ? req_funct3 <= 3'd2 : !(req_funct3 == 3'd3 || req_funct3 >= 3'd6);
    mis = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    be = req_funct3[1:0] == 2'd0 ? 4'b0001 << req_addr[1:0] :
         req_funct3[1:0] == 2'd1 ? 4'b0011 << {req_addr[1], 1'b0} : 4'b1111;
    wd = req_funct3[1:0] == 2'd0 ? {4{req_wdata[7:0]}} :
         req_funct3[1:0] == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    s = dmem_rdata >> {off_q, 3'b000};
    ext = f3_q == 3'd0 ? {{24{s[7]}}, s[7:0]} :
          f3_q == 3'd4 ? {24'd0, s[7:0]} :
          f3_q == 3'd1 ? {{16{s[15]}}, s[15:0]} :
          f3_q == 3'd5 ? {16'd0, s[15:0]} : s;
  end
  // request FSM with registered bus, writeback and exception outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      store_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      rd_q <= '0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      wb_valid <= 1'b0;
      exc_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          store_q <= req_store;
          f3_q <= req_funct3;
          off_q <= req_addr[1:0];
          rd_q <= req_rd;
          if (!legal || mis) begin
            state <= RESP;
            done <= 1'b1;
            exc_valid <= 1'b1;
            exc_cause <= {!legal, req_store};
          end else begin
            state <= ACCESS;
            cnt <= '0;
            dmem_req <= 1'b1;
            dmem_we <= req_store;
            dmem_addr <= {req_addr[31:2], 2'b00};
            dmem_be <= be;
            dmem_wdata <= req_store ? wd : 32'd0;
          end
        end
        ACCESS: if (dmem_ack) begin
          state <= RESP;
          dmem_req <= 1'b0;
          done <= 1'b1;
          if (!store_q) begin
            wb_valid <= 1'b1;
            wb_rd <= rd_q;
            wb_data <= ext;
          end
        end else if (cnt == TMAX) begin
          state <= RESP;
          dmem_req <= 1'b0;
          done <= 1'b1;
          exc_valid <= 1'b1;
          exc_cause <= {1'b1, store_q};
        end else begin
          cnt <= cnt + 8'd1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit against a byte-level reference model
module tb_mem_access_unit;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0] req_rd = '0;
  logic dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0] dmem_be;
  logic wb_valid, exc_valid, done;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic [1:0] exc_cause;
  int checks = 0, errors = 0;
  logic e_ready, e_req, e_we, e_wb, e_exc, e_done;
  logic [31:0] e_addr, e_wd, e_wbd;
  logic [3:0] e_be;
  logic [4:0] e_rd;
  logic [1:0] e_cause;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .exc_valid(exc_valid), .exc_cause(exc_cause), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 ok, 1 misaligned, 2 illegal funct3
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a, d, r,
                                output int kind, output logic [3:0] be, output logic [31:0] wd, ld);
    int nb, off;
    logic [31:0] v;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    kind = (st ? f3 > 3'd2 : (f3 == 3'd3 || f3 >= 3'd6)) ? 2 : (off % nb != 0) ? 1 : 0;
    be = '0;
    wd = '0;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) be[i] = 1'b1;
      if (st) wd[8*i +: 8] = d[8*(i % nb) +: 8];
    end
    for (int j = 0; j < nb && off + j < 4; j++) v[8*j +: 8] = r[8*(off+j) +: 8];
    if (!f3[2] && nb < 4 && v[8*nb-1]) for (int i = 8 * nb; i < 32; i++) v[i] = 1'b1;
    ld = v;
  endfunction

  task automatic set_idle();
    e_ready = 1'b1; e_req = 1'b0; e_done = 1'b0; e_wb = 1'b0; e_exc = 1'b0;
  endtask

  task automatic junk_req();
    req_valid = 1'($urandom % 2);
    req_store = 1'($urandom % 2);
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    req_rd = 5'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      dmem_ack = 1'($urandom % 2);
      set_idle();
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  // ackc: bus cycle (1-based) carrying the ack, 0 = never; rcyc: bus cycle in which reset is pulsed, 0 = none
  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, d, input logic [4:0] rd,
                     input int ackc, input logic [31:0] rdat, input int rcyc);
    int kind;
    logic [3:0] be;
    logic [31:0] wd, ld;
    logic acked;
    model(st, f3, a, d, rdat, kind, be, wd, ld);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d; req_rd = rd;
    dmem_ack = 1'($urandom % 2);
    set_idle();
    @(posedge clk); #1;
    junk_req();
    e_ready = 1'b0; e_done = 1'b0; e_wb = 1'b0; e_exc = 1'b0;
    if (kind != 0) begin
      e_req = 1'b0; e_done = 1'b1; e_exc = 1'b1; e_cause = {kind == 2, st};
      dmem_ack = 1'($urandom % 2);
      @(posedge clk); #1;
    end else begin
      acked = ackc >= 1 && ackc <= TO;
      for (int j = 1; j <= TO; j++) begin
        e_req = 1'b1; e_we = st; e_addr = a & 32'hFFFF_FFFC; e_be = be; e_wd = wd;
        dmem_ack = (j == ackc);
        dmem_rdata = dmem_ack ? rdat : $urandom;
        if (j == rcyc) begin
          #1 rst = 1'b1;
          #1 chk("reset_drops_req", {31'd0, dmem_req}, 32'd0);
          chk("reset_no_done", {31'd0, done}, 32'd0);
          req_valid = 1'b0;
          dmem_ack = 1'b0;
          @(posedge clk); #1;
          rst = 1'b0;
          set_idle();
          return;
        end
        @(posedge clk); #1;
        if (j == ackc) break;
      end
      e_req = 1'b0; e_done = 1'b1;
      e_wb = acked && !st; e_rd = rd; e_wbd = ld;
      e_exc = !acked; e_cause = {1'b1, st};
      dmem_ack = 1'($urandom % 2);
      dmem_rdata = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    dmem_ack = 1'($urandom % 2);
    set_idle();
  endtask

  // single compare process: every cycle out of reset, checks the DUT against the expectations the model set
  always @(negedge clk) if (!rst) begin
    chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
    chk("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_wb});
    chk("exc_valid", {31'd0, exc_valid}, {31'd0, e_exc});
    if (e_req) begin
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_we});
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_be", {28'd0, dmem_be}, {28'd0, e_be});
      chk("dmem_wdata", dmem_wdata, e_wd);
    end
    if (e_wb) begin
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, e_rd});
      chk("wb_data", wb_data, e_wbd);
    end
    if (e_exc) chk("exc_cause", {30'd0, exc_cause}, {30'd0, e_cause});
  end

  initial begin
    int kind, ackc, rcyc;
    logic [3:0] be;
    logic [31:0] wd, ld, a;
    logic [2:0] f3;
    logic st;
    set_idle();
    // model pins from hand-worked examples
    model(0, 3'd0, 32'h103, 0, 32'h80123456, kind, be, wd, ld);
    chk("pin_lb_data", ld, 32'hFFFFFF80);
    chk("pin_lb_be", {28'd0, be}, 32'h8);
    model(0, 3'd4, 32'h103, 0, 32'h80123456, kind, be, wd, ld);
    chk("pin_lbu_data", ld, 32'h00000080);
    model(0, 3'd1, 32'h102, 0, 32'h80123456, kind, be, wd, ld);
    chk("pin_lh_data", ld, 32'hFFFF8012);
    model(1, 3'd0, 32'h201, 32'hA5, 0, kind, be, wd, ld);
    chk("pin_sb_be", {28'd0, be}, 32'h2);
    chk("pin_sb_wd", wd, 32'hA5A5A5A5);
    model(1, 3'd1, 32'h202, 32'h1234, 0, kind, be, wd, ld);
    chk("pin_sh_be", {28'd0, be}, 32'hC);
    chk("pin_sh_wd", wd, 32'h12341234);
    model(0, 3'd2, 32'h102, 0, 0, kind, be, wd, ld);
    chk("pin_lw_misal", kind, 1);
    model(0, 3'd6, 32'h100, 0, 0, kind, be, wd, ld);
    chk("pin_illegal", kind, 2);
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_req", {31'd0, dmem_req}, 0);
    chk("rst_dmem_we", {31'd0, dmem_we}, 0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 0);
    chk("rst_exc_valid", {31'd0, exc_valid}, 0);
    chk("rst_exc_cause", {30'd0, exc_cause}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst = 1'b0;
    idle(2);
    // directed cases
    run(0, 3'd2, 32'h100, 0, 5'd5, 4, 32'hDEADBEEF, 0);
    run(0, 3'd0, 32'h103, 0, 5'd6, 1, 32'h80123456, 0);
    run(0, 3'd4, 32'h103, 0, 5'd7, 2, 32'h80123456, 0);
    run(0, 3'd1, 32'h102, 0, 5'd8, 1, 32'h80123456, 0);
    run(1, 3'd0, 32'h201, 32'h000000A5, 5'd0, 2, 0, 0);
    run(1, 3'd1, 32'h202, 32'h00001234, 5'd0, 1, 0, 0);
    run(0, 3'd2, 32'h102, 0, 5'd9, 1, 0, 0);
    run(1, 3'd1, 32'h301, 0, 5'd0, 1, 0, 0);
    run(0, 3'd7, 32'h100, 0, 5'd1, 1, 0, 0);
    run(1, 3'd2, 32'h500, 32'hCAFEF00D, 5'd0, 0, 0, 0);
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    idle(2);
    run(1, 3'd2, 32'h500, 32'hCAFEF00D, 5'd0, TO, 0, 0);
    run(0, 3'd2, 32'h400, 0, 5'd3, 0, 0, 3);
    idle(1);
    run(0, 3'd2, 32'h400, 0, 5'd3, 2, 32'h01020304, 0);
    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom % 2);
      f3 = ($urandom % 8 == 0) ? 3'($urandom) : st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) | (($urandom % 2) != 0 && $urandom % 3 != 2 ? 3'd4 : 3'd0));
      a = $urandom;
      if ($urandom % 4 != 0) a[1:0] = f3[1:0] == 2'd2 ? 2'd0 : f3[1:0] == 2'd1 ? {a[1], 1'b0} : a[1:0];
      ackc = ($urandom % 8 == 0) ? 0 : $urandom_range(1, TO);
      rcyc = ($urandom % 30 == 0) ? $urandom_range(1, 3) : 0;
      run(st, f3, a, $urandom, 5'($urandom), ackc, $urandom, rcyc);
      if ($urandom % 3 == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage of the RISC-V core, directly downstream of the load/store address generator.
- Accepts one resolved request at a time: effective address, raw store operand, funct3 and load/store flag.
- Checks alignment, builds byte-lane enables and replicated write data, and runs a req/ack transaction on the data-memory bus.
- Returns sign- or zero-extended load data to writeback, or raises an exception.

Parameters:
TIMEOUT, 16, cycles in ACCESS without dmem_ack before a bus fault is raised (legal range 2..255).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_store  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  effective byte address
req_wdata  input  32  store operand (low byte/half/word used)
req_rd  input  5  load destination register
dmem_req  output  1  bus request, held until ack
dmem_we  output  1  write strobe
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_be  output  4  byte-lane enables
dmem_wdata  output  32  lane-replicated store data
dmem_ack  input  1  bus completion, one-cycle pulse
dmem_rdata  input  32  read data, valid with dmem_ack
wb_valid  output  1  one-cycle pulse, load data valid
wb_rd  output  5  destination register
wb_data  output  32  extended load result
exc_valid  output  1  one-cycle exception pulse
exc_cause  output  2  00 load misaligned, 01 store misaligned, 10 load fault, 11 store fault
done  output  1  one-cycle pulse per retired request (normal or exception)

Behaviour:
- Reset (async): state=IDLE, timeout counter=0. dmem_req, dmem_we, dmem_be, wb_valid, exc_valid and done are 0. dmem_addr, dmem_wdata, wb_data, wb_rd and exc_cause are 0. req_ready=1 once reset deasserts.
- All outputs are registered except req_ready, which is high exactly in IDLE.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on req_valid: latch all request fields.
  - Illegal funct3 (load 011/110/111, store 011..111): go to RESP with a fault cause (10 load, 11 store).
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0): go to RESP with cause 00 or 01.
  - Otherwise: go to ACCESS and drive dmem_req=1 with we/addr/be/wdata in the next cycle.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{d[15:0]}}.
  - SW: be=4'b1111, wdata=d.
- Loads: be per width as for stores; dmem_we=0, dmem_wdata=0.
- ACCESS: dmem_req and all bus fields stay stable until dmem_ack. The counter increments each cycle without ack.
  - On ack: capture rdata, drop dmem_req, go to RESP.
  - If counter reaches TIMEOUT-1 with no ack: drop dmem_req, go to RESP with fault cause.
  - Ack in the expiry cycle: ack wins, no fault.
- Load extraction: s = rdata >> (8*addr[1:0]).
  - LB: sign-extend s[7]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15]. LHU: zero-extend s[15:0].
  - LW: s.
- RESP (one cycle): done=1.
  - Successful load: wb_valid=1, wb_rd, wb_data.
  - Exception: exc_valid=1, exc_cause; wb_valid=0.
  - Successful store: done only.
  - Then return to IDLE.
- Latency: request accepted at edge T, dmem_req high from T+1, ack seen at edge T+1+k (k>=0), done/wb_valid high at T+2+k. Exception without bus access: done/exc_valid high at T+1.
- Throughput: at most one request in flight; req_ready=0 in ACCESS and RESP, so a new request is accepted earliest in the cycle after RESP.
- dmem_ack while not in ACCESS (including a late ack after timeout or reset) is ignored.
- Reset mid-ACCESS: dmem_req drops immediately, the transaction is abandoned, and no done/wb/exc is generated.

Test Plan:
- LW addr=0x100, ack after 3 wait cycles, rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, we=0; wb_valid with wb_data=0xDEADBEEF at T+5; done same cycle.
- LB addr=0x103, rdata=0x80123456 -> be=1000, wb_data=0xFFFFFF80. LBU same stimulus -> 0x00000080. LH addr=0x102 -> 0xFFFF8012.
- SB addr=0x201, d=0x000000A5 -> dmem_addr=0x200, be=0010, wdata=0xA5A5A5A5, we=1; done only, no wb_valid. SH addr=0x202, d=0x1234 -> be=1100, wdata=0x12341234.
- LW addr=0x102 -> exc_valid, cause=00 at T+1, dmem_req never asserted. SH addr=0x301 -> cause=01.
- Store, ack never arrives, TIMEOUT=16 -> dmem_req high 16 cycles, then exc cause=11. A late ack in IDLE has no effect. Ack in the 16th cycle instead -> normal done, no exc.
- Assert rst during ACCESS -> dmem_req=0 asynchronously, no done pulse; next request after reset completes normally.
